// File: rtl/ddr2_wdf_calib_fifo.sv
// DDR2 write-data FIFO with a read-calibration pattern loader that owns the
// write port until init_done, after which user write data is accepted.
module ddr2_wdf_calib_fifo #(
    parameter int DQ_WIDTH  = 16,
    parameter int DM_WIDTH  = 2,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int BURST_LEN = 8
) (
    input  logic                       clk0,
    input  logic                       rst,
    input  logic                       init_done,
    input  logic                       calib_restart,
    input  logic [2*DQ_WIDTH-1:0]      app_wdf_data,
    input  logic [2*DM_WIDTH-1:0]      app_mask_data,
    input  logic                       app_wdf_wren,
    input  logic                       ctrl_wdf_rden,
    output logic [2*DQ_WIDTH-1:0]      wdf_data,
    output logic [2*DM_WIDTH-1:0]      mask_data,
    output logic                       wdf_empty,
    output logic                       wdf_full,
    output logic                       wdf_almost_full,
    output logic [$clog2(DEPTH):0]     wdf_count,
    output logic                       pattern_done,
    output logic                       wdf_overflow,
    output logic                       wdf_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(BURST_LEN);
    localparam int DW = 2 * DQ_WIDTH;
    localparam int MW = 2 * DM_WIDTH;

    localparam logic [DW-1:0] PAT_F0 = {{DQ_WIDTH{1'b1}}, {DQ_WIDTH{1'b0}}};
    localparam logic [DW-1:0] PAT_A5 = {{(DQ_WIDTH/2){2'b10}}, {(DQ_WIDTH/2){2'b01}}};
    localparam logic [DW-1:0] PAT_5A = {PAT_A5[DQ_WIDTH-1:0], PAT_A5[DW-1:DQ_WIDTH]};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [MW-1:0]     rmask_q, rmask_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic [DW-1:0]     mem_data [DEPTH];
    logic [MW-1:0]     mem_mask [DEPTH];

    logic              full, empty, pat_push;
    logic              wr_req, wr_acc, rd_acc;
    logic [DW-1:0]     pat_word, wr_data;
    logic [MW-1:0]     wr_mask;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // First half of the burst is F0, the rest alternates A5/5A.
    always_comb begin
        pat_word = PAT_F0;
        if (idx_q >= IW'(BURST_LEN/2))
            pat_word = idx_q[0] ? PAT_5A : PAT_A5;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pat_push = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d   = '0;
                state_d = init_done ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                if (init_done) begin
                    state_d = S_DONE;
                end else if (!full) begin
                    pat_push = 1'b1;
                    if (idx_q == IW'(BURST_LEN-1)) state_d = S_DONE;
                    else                           idx_d   = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (calib_restart && !init_done) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write-port ownership follows init_done; the loader never raises overflow.
    always_comb begin
        wr_req  = init_done ? app_wdf_wren  : pat_push;
        wr_data = init_done ? app_wdf_data  : pat_word;
        wr_mask = init_done ? app_mask_data : '0;
        wr_acc  = wr_req & ~full;
        rd_acc  = ctrl_wdf_rden & ~empty;

        wptr_d  = wr_acc ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = rd_acc ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
        rdata_d = rd_acc ? mem_data[rptr_q] : rdata_q;
        rmask_d = rd_acc ? mem_mask[rptr_q] : rmask_q;
        ovf_d   = ovf_q | (init_done & app_wdf_wren & full);
        unf_d   = unf_q | (ctrl_wdf_rden & empty);
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            rmask_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            rmask_q <= rmask_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk0) begin
        if (wr_acc) begin
            mem_data[wptr_q] <= wr_data;
            mem_mask[wptr_q] <= wr_mask;
        end
    end

    assign wdf_data        = rdata_q;
    assign mask_data       = rmask_q;
    assign wdf_empty       = empty;
    assign wdf_full        = full;
    assign wdf_almost_full = (count_q >= CW'(AF_THRESH));
    assign wdf_count       = count_q;
    assign pattern_done    = (state_q == S_DONE);
    assign wdf_overflow    = ovf_q;
    assign wdf_underflow   = unf_q;

endmodule

// File: tb/tb_ddr2_wdf_calib_fifo.sv
// Randomised bench for ddr2_wdf_calib_fifo: queue-based reference model plus
// literal anchors; a second small instance covers the 4-word pattern at DEPTH=4.
module tb_ddr2_wdf_calib_fifo;
    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    logic        rst = 1'b1, init_done = 1'b0, calib_restart = 1'b0;
    logic        app_wdf_wren = 1'b0, ctrl_wdf_rden = 1'b0;
    logic [31:0] app_wdf_data = '0;
    logic [3:0]  app_mask_data = '0;
    logic [31:0] wdf_data;
    logic [3:0]  mask_data;
    logic        wdf_empty, wdf_full, wdf_almost_full, pattern_done, wdf_overflow, wdf_underflow;
    logic [4:0]  wdf_count;

    logic        b_init = 1'b0, b_restart = 1'b0, b_wren = 1'b0, b_rden = 1'b0;
    logic [31:0] b_wdata = '0, b_data;
    logic [3:0]  b_wmask = '0, b_mask;
    logic        b_empty, b_full, b_af, b_pdone, b_ovf, b_unf;
    logic [2:0]  b_count;

    ddr2_wdf_calib_fifo dut (
        .clk0(clk0), .rst(rst), .init_done(init_done), .calib_restart(calib_restart),
        .app_wdf_data(app_wdf_data), .app_mask_data(app_mask_data),
        .app_wdf_wren(app_wdf_wren), .ctrl_wdf_rden(ctrl_wdf_rden),
        .wdf_data(wdf_data), .mask_data(mask_data), .wdf_empty(wdf_empty),
        .wdf_full(wdf_full), .wdf_almost_full(wdf_almost_full), .wdf_count(wdf_count),
        .pattern_done(pattern_done), .wdf_overflow(wdf_overflow), .wdf_underflow(wdf_underflow)
    );

    ddr2_wdf_calib_fifo #(.DEPTH(4), .AF_THRESH(3), .BURST_LEN(4)) u_bl4 (
        .clk0(clk0), .rst(rst), .init_done(b_init), .calib_restart(b_restart),
        .app_wdf_data(b_wdata), .app_mask_data(b_wmask),
        .app_wdf_wren(b_wren), .ctrl_wdf_rden(b_rden),
        .wdf_data(b_data), .mask_data(b_mask), .wdf_empty(b_empty),
        .wdf_full(b_full), .wdf_almost_full(b_af), .wdf_count(b_count),
        .pattern_done(b_pdone), .wdf_overflow(b_ovf), .wdf_underflow(b_unf)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    logic [31:0] pat8 [8] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000,
                              32'hAAAA5555, 32'h5555AAAA, 32'hAAAA5555, 32'h5555AAAA};
    logic [31:0] pat4 [4] = '{32'hFFFF0000, 32'hFFFF0000, 32'hAAAA5555, 32'h5555AAAA};

    // Reference model: the FIFO is a queue; loader progress is a phase plus word index.
    logic [35:0] mq[$];
    int          m_ph = 0, m_idx = 0;   // 0 waiting, 1 loading, 2 done
    bit          m_ovf = 0, m_unf = 0, started = 0;
    logic [31:0] m_d = '0;
    logic [3:0]  m_m = '0;

    always @(posedge clk0) begin : mdl
        int n;
        bit mfull, mempty, wr;
        logic [35:0] w;
        started = 1;
        if (rst) begin
            mq.delete(); m_ph = 0; m_idx = 0; m_ovf = 0; m_unf = 0; m_d = '0; m_m = '0;
        end else begin
            n = mq.size(); mfull = (n == 16); mempty = (n == 0); wr = 0; w = '0;
            if (ctrl_wdf_rden && mempty) m_unf = 1;
            if (init_done) begin
                if (app_wdf_wren) begin
                    if (mfull) m_ovf = 1;
                    else begin wr = 1; w = {app_mask_data, app_wdf_data}; end
                end
            end else if (m_ph == 1 && !mfull) begin
                wr = 1; w = {4'h0, pat8[m_idx]};
            end
            case (m_ph)
                0: begin m_ph = init_done ? 2 : 1; m_idx = 0; end
                1: if (init_done) m_ph = 2;
                   else if (!mfull) begin m_idx++; if (m_idx == 8) m_ph = 2; end
                default: if (calib_restart && !init_done) begin m_ph = 1; m_idx = 0; end
            endcase
            if (ctrl_wdf_rden && !mempty) {m_m, m_d} = mq.pop_front();
            if (wr) mq.push_back(w);
        end
    end

    always @(negedge clk0) begin
        if (started) begin
            chk("wdf_data",     wdf_data,        m_d);
            chk("mask_data",    mask_data,       m_m);
            chk("wdf_count",    wdf_count,       mq.size());
            chk("wdf_empty",    wdf_empty,       mq.size() == 0);
            chk("wdf_full",     wdf_full,        mq.size() == 16);
            chk("almost_full",  wdf_almost_full, mq.size() >= 12);
            chk("pattern_done", pattern_done,    m_ph == 2);
            chk("overflow",     wdf_overflow,    m_ovf);
            chk("underflow",    wdf_underflow,   m_unf);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk0);
    endtask

    task automatic pulse_restart();
        calib_restart = 1'b1; tick(1); calib_restart = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst count", wdf_count, 0);
        chk("rst empty", wdf_empty, 1);
        chk("rst pdone", pattern_done, 0);
        chk("rst data",  wdf_data, 0);

        // Full 8-word pattern, and the 4-word pattern stalling at DEPTH=4.
        rst = 1'b0; tick(10);
        chk("bl8 count", wdf_count, 8);
        chk("bl8 pdone", pattern_done, 1);
        chk("bl4 count", b_count, 4);
        chk("bl4 full",  b_full, 1);
        ctrl_wdf_rden = 1'b1; b_rden = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("bl8 word", wdf_data, pat8[i]);
            if (i < 4) chk("bl4 word", b_data, pat4[i]);
            if (i == 3) b_rden = 1'b0;
        end
        ctrl_wdf_rden = 1'b0; tick(1);
        chk("bl8 drained", wdf_empty, 1);
        chk("bl4 drained", b_empty, 1);

        // Replays fill the FIFO, the third one stalls on full.
        pulse_restart(); tick(10);
        pulse_restart(); tick(10);
        chk("two replays", wdf_count, 16);
        pulse_restart(); tick(3);
        chk("stall count", wdf_count, 16);
        chk("stall pdone", pattern_done, 0);
        ctrl_wdf_rden = 1'b1; tick(24); ctrl_wdf_rden = 1'b0; tick(1);
        chk("stall drain", wdf_count, 0);
        chk("stall pdone2", pattern_done, 1);
        chk("stall no unf", wdf_underflow, 0);

        // Abort after three pattern pushes, then user data follows.
        rst = 1'b1; tick(2); rst = 1'b0; tick(4);
        init_done = 1'b1; tick(2);
        chk("abort count", wdf_count, 3);
        chk("abort pdone", pattern_done, 1);
        app_wdf_wren = 1'b1; app_wdf_data = 32'h1234ABCD; app_mask_data = 4'h5;
        tick(1); app_wdf_wren = 1'b0;
        ctrl_wdf_rden = 1'b1; tick(4); ctrl_wdf_rden = 1'b0;
        chk("abort app word", wdf_data, 32'h1234ABCD);
        chk("abort app mask", mask_data, 4'h5);

        // Fill past full, drain past empty.
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        app_wdf_wren = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            app_wdf_data = $urandom; app_mask_data = 4'($urandom);
            tick(1);
            if (i == 11) chk("af at 11", wdf_almost_full, 0);
            if (i == 12) chk("af at 12", wdf_almost_full, 1);
            if (i == 16) chk("full at 16", wdf_full, 1);
        end
        app_wdf_wren = 1'b0;
        chk("ovf set", wdf_overflow, 1);
        chk("ovf count", wdf_count, 16);
        ctrl_wdf_rden = 1'b1; tick(17); ctrl_wdf_rden = 1'b0;
        chk("unf set", wdf_underflow, 1);
        chk("unf empty", wdf_empty, 1);

        // Simultaneous read and write at count 5.
        app_wdf_wren = 1'b1; tick(5);
        ctrl_wdf_rden = 1'b1; tick(1);
        app_wdf_wren = 1'b0; ctrl_wdf_rden = 1'b0;
        chk("rw count 5", wdf_count, 5);

        // Random traffic with shifting read/write bias and occasional mode changes.
        for (int c = 0; c < 3000; c++) begin
            int wp, rp;
            wp = ((c / 200) % 3 == 0) ? 80 : ((c / 200) % 3 == 1) ? 30 : 55;
            rp = 110 - wp;
            app_wdf_wren  = ($urandom_range(99) < wp);
            ctrl_wdf_rden = ($urandom_range(99) < rp);
            app_wdf_data  = $urandom;
            app_mask_data = 4'($urandom);
            calib_restart = ($urandom_range(19) == 0);
            if ($urandom_range(149) == 0) init_done = ~init_done;
            rst = ($urandom_range(499) == 0);
            tick(1);
        end
        rst = 1'b0; app_wdf_wren = 1'b0; ctrl_wdf_rden = 1'b0; calib_restart = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
